// File: rtl/td4_pkg.sv
// Shared constants for the TD4 execute stage: default width, LOAD bit
// positions and SELECT source encodings.
package td4_pkg;

   localparam int TD4_WIDTH = 4;

   localparam int LD_A   = 0;
   localparam int LD_B   = 1;
   localparam int LD_OUT = 2;
   localparam int LD_PC  = 3;

   localparam logic [1:0] SEL_A    = 2'b00;
   localparam logic [1:0] SEL_B    = 2'b01;
   localparam logic [1:0] SEL_IN   = 2'b10;
   localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/td4_alu.sv
// Source mux plus adder for the TD4 execute stage; purely combinational.
// The carry out is the extra top bit of a WIDTH+1 bit addition.
module td4_alu
   import td4_pkg::*;
#(
   parameter int WIDTH = TD4_WIDTH
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] in_port,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH-1:0] mux;

   always_comb begin
      mux = '0;
      case (sel)
         SEL_A:    mux = a;
         SEL_B:    mux = b;
         SEL_IN:   mux = in_port;
         SEL_ZERO: mux = '0;
      endcase
   end

   assign {cout, sum} = {1'b0, mux} + {1'b0, imm};

endmodule

// File: rtl/td4_datapath.sv
// TD4 execute stage: A/B/OUT/PC registers, carry flag, sticky self-jump
// detect and a saturating retired-instruction counter.
module td4_datapath
   import td4_pkg::*;
#(
   parameter int WIDTH     = TD4_WIDTH,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 EN,
   input  logic [3:0]           LOAD,
   input  logic [1:0]           SELECT,
   input  logic [WIDTH-1:0]     IMM,
   input  logic [WIDTH-1:0]     IN_PORT,
   output logic [WIDTH-1:0]     PC,
   output logic [WIDTH-1:0]     OUT_PORT,
   output logic                 CARRY,
   output logic [WIDTH-1:0]     REG_A,
   output logic [WIDTH-1:0]     REG_B,
   output logic                 HALTED,
   output logic [CNT_WIDTH-1:0] INSTR_COUNT
);

   logic [WIDTH-1:0]     reg_a, reg_b, reg_out, pc;
   logic                 carry, halted;
   logic [CNT_WIDTH-1:0] instr_count;
   logic [WIDTH-1:0]     sum;
   logic                 cout;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   td4_alu #(.WIDTH(WIDTH)) u_alu (
      .sel     (SELECT),
      .a       (reg_a),
      .b       (reg_b),
      .in_port (IN_PORT),
      .imm     (IMM),
      .sum     (sum),
      .cout    (cout)
   );

   // Carry is captured on every retired instruction, so a conditional jump
   // always sees the carry of the instruction just before it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         reg_a       <= '0;
         reg_b       <= '0;
         reg_out     <= '0;
         pc          <= '0;
         carry       <= 1'b0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else if (EN) begin
         if (!LOAD[LD_A])   reg_a   <= sum;
         if (!LOAD[LD_B])   reg_b   <= sum;
         if (!LOAD[LD_OUT]) reg_out <= sum;
         if (!LOAD[LD_PC])  pc      <= sum;
         else               pc      <= pc + 1'b1;
         carry       <= cout;
         instr_count <= sat_inc(instr_count);
         if (!LOAD[LD_PC] && (sum == pc)) halted <= 1'b1;
      end
   end

   assign PC          = pc;
   assign OUT_PORT    = reg_out;
   assign CARRY       = carry;
   assign REG_A       = reg_a;
   assign REG_B       = reg_b;
   assign HALTED      = halted;
   assign INSTR_COUNT = instr_count;

endmodule
